// File: rtl/base_vqueue_pkg.sv
// Shared constants and payload merge helper for the unique-tag queue.
// A duplicate arrival's payload is combined with the stored one by mode.
package base_vqueue_pkg;

  localparam int VQ_DROP    = 0;
  localparam int VQ_REPLACE = 1;
  localparam int VQ_OR      = 2;

  localparam int VQ_DW_MAX = 64;

  typedef logic [VQ_DW_MAX-1:0] vq_data_t;

  function automatic vq_data_t vq_merge(
    input int       m,
    input vq_data_t old_d,
    input vq_data_t new_d
  );
    vq_data_t r;
    r = old_d;
    case (m)
      VQ_REPLACE: r = new_d;
      VQ_OR:      r = old_d | new_d;
      default:    r = old_d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/base_vqueue_tagring.sv
// Circular FIFO of tags waiting behind the output head register.
// Pointers wrap naturally; cnt carries one extra bit so full is its MSB.
module base_vqueue_tagring #(
  parameter int tag_width = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic [tag_width-1:0] push_tag,
  input  logic                 pop,
  output logic [tag_width-1:0] head,
  output logic [tag_width:0]   cnt,
  output logic                 empty,
  output logic                 full
);

  localparam int DEPTH = 1 << tag_width;

  logic [tag_width-1:0] mem [DEPTH];
  logic [tag_width-1:0] rd;
  logic [tag_width-1:0] wr;

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= push_tag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else if (flush) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd];
  assign empty = (cnt == '0);
  assign full  = cnt[tag_width];

endmodule

// File: rtl/base_vqueue_merge.sv
// Unique-tag FIFO with per-tag payload; duplicates drop, replace or OR-merge.
// Pending = ring entries plus a valid head, so count is derived from both.
module base_vqueue_merge
  import base_vqueue_pkg::*;
#(
  parameter int tag_width  = 4,
  parameter int data_width = 8,
  parameter int mode       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  i_v,
  output logic                  i_r,
  input  logic [0:tag_width-1]  i_tag,
  input  logic [0:data_width-1] i_d,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [0:tag_width-1]  o_tag,
  output logic [0:data_width-1] o_d,
  output logic [0:tag_width]    count,
  output logic                  dup_hit
);

  localparam int DEPTH = 1 << tag_width;

  typedef logic [tag_width-1:0]  tag_t;
  typedef logic [data_width-1:0] dat_t;

  tag_t tag;
  tag_t head_tag;
  tag_t ring_head;
  tag_t load_tag;
  dat_t din;
  dat_t head_d;
  dat_t merged;
  dat_t load_d;

  logic [DEPTH-1:0] pend;
  dat_t             pay [DEPTH];

  logic [tag_width:0] ring_cnt;
  logic ring_empty;
  logic ring_full;

  logic acc;
  logic hs;
  logic dup;
  logic new_acc;
  logic head_free;
  logic load;
  logic bypass;
  logic pop;
  logic push;
  logic head_dup;

  assign tag   = i_tag;
  assign din   = i_d;
  assign o_tag = head_tag;
  assign o_d   = head_d;
  assign i_r   = ~flush;
  assign count = ring_cnt + {{tag_width{1'b0}}, o_v};

  assign acc = i_v & ~flush;
  assign hs  = o_v & o_r;

  // A tag leaving the head this cycle is no longer pending: re-arrival is new.
  assign dup       = acc & pend[tag] & ~(hs & (head_tag == tag));
  assign new_acc   = acc & ~dup;
  assign head_dup  = dup & o_v & (head_tag == tag);
  assign head_free = ~o_v | hs;
  assign load      = head_free & (~ring_empty | new_acc) & ~flush;
  assign bypass    = load & ring_empty;
  assign pop       = load & ~ring_empty;
  assign push      = new_acc & ~bypass & ~ring_full;

  assign merged = data_width'(vq_merge(mode,
                                       VQ_DW_MAX'(pay[tag]),
                                       VQ_DW_MAX'(din)));

  assign load_tag = bypass ? tag : ring_head;

  always_comb begin
    load_d = pay[ring_head];
    if (bypass) load_d = din;
    else if (dup && (ring_head == tag)) load_d = merged;
  end

  base_vqueue_tagring #(
    .tag_width(tag_width)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .push_tag(tag),
    .pop     (pop),
    .head    (ring_head),
    .cnt     (ring_cnt),
    .empty   (ring_empty),
    .full    (ring_full)
  );

  always_ff @(posedge clk) begin
    if (acc) pay[tag] <= new_acc ? din : merged;
  end

  // Set after clear so a same-cycle re-arrival keeps its pend bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
    end else if (flush) begin
      pend <= '0;
    end else begin
      if (hs)      pend[head_tag] <= 1'b0;
      if (new_acc) pend[tag]      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_v      <= 1'b0;
      head_tag <= '0;
      head_d   <= '0;
      dup_hit  <= 1'b0;
    end else if (flush) begin
      o_v     <= 1'b0;
      dup_hit <= 1'b0;
    end else begin
      dup_hit <= dup;
      if (load) begin
        o_v      <= 1'b1;
        head_tag <= load_tag;
        head_d   <= load_d;
      end else if (hs) begin
        o_v <= 1'b0;
      end else if (head_dup) begin
        head_d <= merged;
      end
    end
  end

endmodule
